// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_USE  = 2'd1,
    ST_DMEM_WAIT = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the core pipeline (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [1:0]        id_rs_used;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_load;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic              ex_redirect;
  logic              dmem_request;
  logic              dmem_valid;
  logic              imem_valid;

  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              flush_id;
  logic              flush_ex;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              bus_error;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs_used, ex_rd, ex_reg_write, ex_load,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_redirect,
           dmem_request, dmem_valid, imem_valid,
    input  stall_if, stall_id, stall_ex, flush_id, flush_ex,
           fwd_a_sel, fwd_b_sel, bus_error, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs_used, ex_rd, ex_reg_write, ex_load,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_redirect,
           dmem_request, dmem_valid, imem_valid,
    output stall_if, stall_id, stall_ex, flush_id, flush_ex,
           fwd_a_sel, fwd_b_sel, bus_error, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand forwarding source select; the mem stage is younger and wins over wb.
module pipe_hazard_ctrl_fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter bit          WB_EN  = 1'b0
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel_c
);

  always_comb begin
    sel_c = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel_c = FWD_MEM;
    end else if (WB_EN && wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forwarding controller: load-use bubbles, dmem freeze with
// timeout, EX redirect flush, imem bubble and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned DMEM_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int unsigned BUB_W = (LU_BUBBLES > 1) ? $clog2(LU_BUBBLES) : 1;
  localparam int unsigned TMO_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [BUB_W-1:0] BUB_LAST = BUB_W'(LU_BUBBLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DMEM_TIMEOUT - 1);
  localparam bit WB_EN = (NUM_STAGES == 5);

  state_e             state, state_nxt;
  logic [BUB_W-1:0]   bub_cnt, bub_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               bus_error_q, bus_error_nxt;
  logic               stall_if_s, stall_id_s, stall_ex_s, flush_id_s, flush_ex_s;
  logic               lu_hazard;

  assign lu_hazard = bus.ex_load && bus.ex_reg_write && (bus.ex_rd != '0) &&
                     ((bus.id_rs_used[0] && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_rs_used[1] && (bus.id_rs2 == bus.ex_rd)));

  // Next state and per-state pipe control.
  always_comb begin
    state_nxt     = state;
    bub_nxt       = bub_cnt;
    tmo_nxt       = '0;
    bus_error_nxt = 1'b0;
    stall_if_s    = 1'b0;
    stall_id_s    = 1'b0;
    stall_ex_s    = 1'b0;
    flush_id_s    = 1'b0;
    flush_ex_s    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (bus.dmem_request && !bus.dmem_valid) begin
          state_nxt = ST_DMEM_WAIT;
        end else if (bus.ex_redirect) begin
          state_nxt = ST_REDIRECT;
        end else if (lu_hazard) begin
          state_nxt = ST_LOAD_USE;
          bub_nxt   = '0;
        end
        if (!bus.imem_valid) begin
          stall_if_s = 1'b1;
          flush_id_s = 1'b1;
        end
      end
      ST_LOAD_USE: begin
        stall_if_s = 1'b1;
        stall_id_s = 1'b1;
        flush_ex_s = 1'b1;
        if (bub_cnt == BUB_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          bub_nxt = BUB_W'(bub_cnt + 1'b1);
        end
      end
      ST_DMEM_WAIT: begin
        stall_if_s = 1'b1;
        stall_id_s = 1'b1;
        stall_ex_s = 1'b1;
        tmo_nxt    = TMO_W'(tmo_cnt + 1'b1);
        if (bus.dmem_valid) begin
          state_nxt = ST_RUN;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt     = ST_RUN;
          bus_error_nxt = 1'b1;
        end
      end
      ST_REDIRECT: begin
        flush_id_s = 1'b1;
        flush_ex_s = 1'b1;
        state_nxt  = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      bub_cnt     <= '0;
      tmo_cnt     <= '0;
      bus_error_q <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      bub_cnt     <= bub_nxt;
      tmo_cnt     <= tmo_nxt;
      bus_error_q <= bus_error_nxt;
      if (stall_if_s && (stall_cnt != '1)) begin
        stall_cnt <= CNT_W'(stall_cnt + 1'b1);
      end
    end
  end

  // Reset holds stalls low and loads bubbles into ID/EX.
  assign bus.stall_if     = stall_if_s & ~rst;
  assign bus.stall_id     = stall_id_s & ~rst;
  assign bus.stall_ex     = stall_ex_s & ~rst;
  assign bus.flush_id     = flush_id_s | rst;
  assign bus.flush_ex     = flush_ex_s | rst;
  assign bus.bus_error    = bus_error_q;
  assign bus.stall_cycles = stall_cnt;

  pipe_hazard_ctrl_fwd_select #(.REG_AW(REG_AW), .WB_EN(WB_EN)) u_fwd_a (
    .rs            (bus.id_rs1),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .sel_c         (bus.fwd_a_sel)
  );

  pipe_hazard_ctrl_fwd_select #(.REG_AW(REG_AW), .WB_EN(WB_EN)) u_fwd_b (
    .rs            (bus.id_rs2),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .sel_c         (bus.fwd_b_sel)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_a is 5-stage/1 bubble/16-bit counter, dut_b is
// 4-stage/3 bubbles/4-bit counter; both see the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0] id_rs_used;
  logic       ex_reg_write, ex_load, mem_reg_write, wb_reg_write;
  logic       ex_redirect, dmem_request, dmem_valid, imem_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus_a ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  bus_b ();

  assign bus_a.id_rs1 = id_rs1;               assign bus_b.id_rs1 = id_rs1;
  assign bus_a.id_rs2 = id_rs2;               assign bus_b.id_rs2 = id_rs2;
  assign bus_a.id_rs_used = id_rs_used;       assign bus_b.id_rs_used = id_rs_used;
  assign bus_a.ex_rd = ex_rd;                 assign bus_b.ex_rd = ex_rd;
  assign bus_a.ex_reg_write = ex_reg_write;   assign bus_b.ex_reg_write = ex_reg_write;
  assign bus_a.ex_load = ex_load;             assign bus_b.ex_load = ex_load;
  assign bus_a.mem_rd = mem_rd;               assign bus_b.mem_rd = mem_rd;
  assign bus_a.mem_reg_write = mem_reg_write; assign bus_b.mem_reg_write = mem_reg_write;
  assign bus_a.wb_rd = wb_rd;                 assign bus_b.wb_rd = wb_rd;
  assign bus_a.wb_reg_write = wb_reg_write;   assign bus_b.wb_reg_write = wb_reg_write;
  assign bus_a.ex_redirect = ex_redirect;     assign bus_b.ex_redirect = ex_redirect;
  assign bus_a.dmem_request = dmem_request;   assign bus_b.dmem_request = dmem_request;
  assign bus_a.dmem_valid = dmem_valid;       assign bus_b.dmem_valid = dmem_valid;
  assign bus_a.imem_valid = imem_valid;       assign bus_b.imem_valid = imem_valid;

  pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_AW(5), .LU_BUBBLES(1), .DMEM_TIMEOUT(64), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  pipe_hazard_ctrl #(.NUM_STAGES(4), .REG_AW(5), .LU_BUBBLES(3), .DMEM_TIMEOUT(64), .CNT_W(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rs_used = 2'b00;
    ex_rd = '0; ex_reg_write = 1'b0; ex_load = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    ex_redirect = 1'b0; dmem_request = 1'b0; dmem_valid = 1'b0; imem_valid = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [1:0] used);
    ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_rs_used = used;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    idle_inputs();
    rst = 1'b1;
    imem_valid = 1'b0;
    mem_rd = 5'd7; mem_reg_write = 1'b1; id_rs2 = 5'd7;
    tick();
    #1;
    check("rst_flush_id", 32'(bus_a.flush_id), 1);
    check("rst_flush_ex", 32'(bus_a.flush_ex), 1);
    check("rst_stall_if", 32'(bus_a.stall_if), 0);
    check("rst_stall_ex", 32'(bus_b.stall_ex), 0);
    check("rst_cnt", 32'(bus_a.stall_cycles), 0);
    check("rst_fwd_live", 32'(bus_a.fwd_b_sel), 1);
    idle_inputs();
    rst = 1'b0;
    tick();
    check("rel_flush_id", 32'(bus_a.flush_id), 0);
    check("rel_flush_ex", 32'(bus_b.flush_ex), 0);
    check("rel_stall_if", 32'(bus_a.stall_if), 0);

    // Forwarding: mem beats wb, x0 never forwards, wb only on 5 stages.
    mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd7; wb_reg_write = 1'b1; id_rs2 = 5'd7;
    #1 check("fwd_b_mem", 32'(bus_a.fwd_b_sel), 1);
    mem_rd = 5'd0; id_rs1 = 5'd0;
    #1 check("fwd_a_x0", 32'(bus_a.fwd_a_sel), 0);
    mem_rd = 5'd3; wb_rd = 5'd9; id_rs1 = 5'd9;
    #1 check("fwd_a_wb5", 32'(bus_a.fwd_a_sel), 2);
    check("fwd_a_wb4", 32'(bus_b.fwd_a_sel), 0);
    wb_reg_write = 1'b0;
    #1 check("fwd_a_nowr", 32'(bus_a.fwd_a_sel), 0);
    mem_rd = 5'd9; mem_reg_write = 1'b0; wb_reg_write = 1'b1;
    #1 check("fwd_a_memoff", 32'(bus_a.fwd_a_sel), 2);
    idle_inputs();
    tick();

    // Load-use: 1 bubble on dut_a, 3 on dut_b.
    do_reset();
    set_load_use(5'd5, 5'd5, 5'd0, 2'b01);
    tick();
    idle_inputs();
    check("lu_stall_if", 32'(bus_a.stall_if), 1);
    check("lu_stall_id", 32'(bus_a.stall_id), 1);
    check("lu_flush_ex", 32'(bus_a.flush_ex), 1);
    check("lu_stall_ex", 32'(bus_a.stall_ex), 0);
    check("lu_b_c1", 32'(bus_b.stall_if), 1);
    tick();
    check("lu_a_done", 32'(bus_a.stall_if), 0);
    check("lu_a_cnt", 32'(bus_a.stall_cycles), 1);
    check("lu_b_c2", 32'(bus_b.stall_id), 1);
    tick();
    check("lu_b_c3", 32'(bus_b.flush_ex), 1);
    tick();
    check("lu_b_done", 32'(bus_b.stall_if), 0);
    check("lu_b_cnt", 32'(bus_b.stall_cycles), 3);

    // Non-hazards: unused rs2, and rd = x0.
    set_load_use(5'd5, 5'd4, 5'd5, 2'b01);
    tick();
    idle_inputs();
    check("lu_unused_rs", 32'(bus_a.stall_if), 0);
    set_load_use(5'd0, 5'd0, 5'd0, 2'b11);
    tick();
    idle_inputs();
    check("lu_rd_x0", 32'(bus_b.stall_id), 0);

    // Redirect beats load-use.
    set_load_use(5'd5, 5'd5, 5'd0, 2'b01);
    ex_redirect = 1'b1;
    tick();
    idle_inputs();
    check("rdr_flush_id", 32'(bus_a.flush_id), 1);
    check("rdr_flush_ex", 32'(bus_b.flush_ex), 1);
    check("rdr_no_stall", 32'(bus_b.stall_if | bus_b.stall_id), 0);
    tick();
    check("rdr_done", 32'(bus_a.flush_id | bus_a.stall_if), 0);

    // imem bubble in RUN.
    imem_valid = 1'b0;
    #1;
    check("imem_stall_if", 32'(bus_a.stall_if), 1);
    check("imem_flush_id", 32'(bus_a.flush_id), 1);
    check("imem_stall_id", 32'(bus_a.stall_id), 0);
    imem_valid = 1'b1;
    tick();

    // dmem wait of 4 cycles.
    do_reset();
    dmem_request = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("dm_stalls", 32'({bus_a.stall_if, bus_a.stall_id, bus_a.stall_ex}), 32'h7);
      if (i == 3) begin
        dmem_valid = 1'b1; dmem_request = 1'b0;
      end
      tick();
    end
    dmem_valid = 1'b0;
    check("dm_release", 32'(bus_a.stall_ex), 0);
    check("dm_cnt", 32'(bus_a.stall_cycles), 4);

    // Redirect held during dmem wait is deferred until after exit.
    dmem_request = 1'b1;
    tick();
    ex_redirect = 1'b1;
    tick();
    check("dmr_ignored", 32'(bus_a.flush_id), 0);
    check("dmr_stall", 32'(bus_a.stall_ex), 1);
    dmem_valid = 1'b1; dmem_request = 1'b0;
    tick();
    dmem_valid = 1'b0;
    check("dmr_run", 32'(bus_a.stall_ex | bus_a.flush_id), 0);
    tick();
    ex_redirect = 1'b0;
    check("dmr_flush", 32'({bus_a.flush_id, bus_a.flush_ex}), 32'h3);
    tick();
    check("dmr_done", 32'(bus_a.flush_id), 0);

    // Timeout: 64 cycles waiting then one bus_error pulse.
    do_reset();
    dmem_request = 1'b1;
    tick();
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      if (!bus_a.stall_ex || bus_a.bus_error || bus_b.bus_error) bad++;
      if (i == 64) dmem_request = 1'b0;
      tick();
    end
    check("tmo_wait", 32'(bad), 0);
    check("tmo_pulse_a", 32'(bus_a.bus_error), 1);
    check("tmo_pulse_b", 32'(bus_b.bus_error), 1);
    check("tmo_run", 32'(bus_a.stall_ex), 0);
    tick();
    check("tmo_single", 32'(bus_a.bus_error), 0);

    // Async reset in the middle of a dmem wait.
    dmem_request = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    dmem_request = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus_a.stall_ex), 0);
    check("mid_rst_cnt", 32'(bus_a.stall_cycles), 0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_run", 32'(bus_a.stall_if), 0);

    // Saturation: 20 stall cycles on the 4-bit counter.
    do_reset();
    dmem_request = 1'b1;
    tick();
    repeat (19) tick();
    dmem_valid = 1'b1; dmem_request = 1'b0;
    tick();
    dmem_valid = 1'b0;
    check("sat_a", 32'(bus_a.stall_cycles), 20);
    check("sat_b", 32'(bus_b.stall_cycles), 15);
    tick();
    tick();
    check("sat_b_hold", 32'(bus_b.stall_cycles), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
